// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, operands shifted LSB-first, carry held in a flop.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cell_s;
  logic             cell_c;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Full-adder cell fed from the operand LSBs and the held carry.
  always_comb begin
    cell_s = fa_sum(sa_q[0], sb_q[0], carry_q);
    cell_c = fa_carry(sa_q[0], sb_q[0], carry_q);
  end

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d   = {cell_s, sum_q[WIDTH-1:1]};
        sa_d    = {1'b0, sa_q[WIDTH-1:1]};
        sb_d    = {1'b0, sb_q[WIDTH-1:1]};
        carry_d = cell_c;
        if (cnt_q == CW'(WIDTH - 1)) begin
          cout_d  = cell_c;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB on this final step.
          ovf_d   = carry_q ^ cell_c;
`endif
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= {WIDTH{1'b0}};
      sb_q    <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases plus random operands
// checked against an arithmetic reference model.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact unsigned sum, and signed overflow from the true signed result.
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
    return WIDTH'(0) + {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic c);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (s > 127) || (s < -128);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation. chain keeps start high so the DONE edge accepts (na, nb, nc).
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tc,
                        input int glitch_at, input bit chain,
                        input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb, input logic nc);
    logic [WIDTH:0] exp;
    exp = ref_add(ta, tb, tc);
    a = ta; b = tb; cin = tc; start = 1'b1;
    step();
    if (chain) begin
      a = na; b = nb; cin = nc;
    end else begin
      start = 1'b0;
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    end
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("done_after_accept", 32'(done), 32'd0);
    for (int i = 1; i < WIDTH; i++) begin
      if (!chain) begin
        start = (i == glitch_at);
        if (i == glitch_at) begin
          a = 8'hFF; b = 8'hFF;
        end
      end
      step();
      chk("busy_in_run", 32'(busy), 32'd1);
      chk("done_in_run", 32'(done), 32'd0);
    end
    if (!chain) start = 1'b0;
    step();
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("sum", 32'(sum), 32'(exp[WIDTH-1:0]));
    chk("cout", 32'(cout), 32'(exp[WIDTH]));
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", 32'(ovf), 32'(ref_ovf(ta, tb, tc)));
`endif
    if (!chain) begin
      step();
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("sum_held", 32'(sum), 32'(exp[WIDTH-1:0]));
      chk("cout_held", 32'(cout), 32'(exp[WIDTH]));
    end
  endtask

  initial begin
    int seen_done;
    logic [WIDTH-1:0] ra, rb;
    logic rc;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Directed corner cases.
    run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 0, 1'b0, 8'h00, 8'h00, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Start re-asserted with new operands during RUN is ignored.
    run_op(8'h12, 8'h34, 1'b0, 3, 1'b0, 8'h00, 8'h00, 1'b0);

    // Reset in the middle of RUN aborts without a done pulse.
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    chk("no_done_after_abort", 32'(seen_done), 32'd0);
    run_op(8'hA5, 8'h5B, 1'b1, 0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Back-to-back: start held high, one result every WIDTH+1 cycles.
    run_op(8'h11, 8'h22, 1'b0, 0, 1'b1, 8'hF0, 8'h0F, 1'b1);
    run_op(8'hF0, 8'h0F, 1'b1, 0, 1'b1, 8'h99, 8'h88, 1'b0);
    run_op(8'h99, 8'h88, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Random operands.
    for (int n = 0; n < 25; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, int'($urandom_range(0, WIDTH - 1)), 1'b0, 8'h00, 8'h00, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
